fifo_sync_fwft: RTL
===================

# fifo_sync_fwft

Parametrised single-clock FIFO and next-generation buffer for the datapath. Configurable width, depth and read mode: registered-output (standard) or first-word-fall-through (FWFT). Adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. Sits between any producer/consumer pair sharing `clk`.

## Interface
- `DATA_WIDTH`, 32: word width in bits.
- `DEPTH`, 8: entries; power of two, ≥ 2.
- `FWFT`, 0: 0 = standard registered read; 1 = first-word-fall-through.
- `AF_LEVEL`, DEPTH-2: `almost_full` asserts when count ≥ AF_LEVEL.
- `AE_LEVEL`, 2: `almost_empty` asserts when count ≤ AE_LEVEL.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cs`  in  1  chip select; gates `wr_en` and `rd_en` only.
- `flush`  in  1  synchronous clear; independent of `cs`.
- `wr_en`  in  1  write request.
- `data_in`  in  DATA_WIDTH  write data.
- `rd_en`  in  1  read request (pop in FWFT mode).
- `data_out`  out  DATA_WIDTH  read data.
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.
- `almost_full`  out  1  count ≥ AF_LEVEL.
- `almost_empty`  out  1  count ≤ AE_LEVEL.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a write was attempted while full.
- `underflow`  out  1  sticky: a read was attempted while empty.

## Operation
- Pointers `wptr` and `rptr` are $clog2(DEPTH)+1 bits wide. Storage is indexed by the low bits. The MSB distinguishes full from empty.
- `count = wptr - rptr`, computed modulo 2^(log2 DEPTH + 1). The result is always in the range 0..DEPTH.
- Write accept: `cs && wr_en && !full`. Stores `data_in` at `wptr` and increments `wptr`.
- Read accept: `cs && rd_en && !empty`. Increments `rptr`.
- `full` and `empty` are evaluated on pre-edge state:
  - When full, a simultaneous read and write performs the read only.
  - When empty, a simultaneous read and write performs the write only.
  - In all other cases both operations proceed and count is unchanged.
- Standard mode (`FWFT=0`):
  - On an accepted read, `data_out` is loaded with `mem[rptr]`.
  - Otherwise `data_out` holds its value.
- FWFT mode (`FWFT=1`):
  - `data_out = mem[rptr]` combinationally while `!empty`; it is 0 while empty.
  - An accepted read pops the head, and the next entry appears after the edge.
- Error flags:
  - `overflow` sets on `cs && wr_en && full`.
  - `underflow` sets on `cs && rd_en && empty`.
  - Both hold until flush or reset. A rejected access changes no other state.
- `flush` has priority over every read and write in the same cycle. It clears pointers, `overflow` and `underflow`, and the standard-mode `data_out` register. Memory contents are not cleared.
- `cs=0`: reads and writes are ignored and no error flag sets.

## Timing
- Reset (asynchronous assert, synchronous use): pointers 0, `data_out` 0, `count` 0, `empty` 1, `full` 0, `almost_empty` 1, `almost_full` = (AF_LEVEL == 0), `overflow` 0, `underflow` 0.
- Status outputs are combinational from registered pointers. They reflect an accepted operation in the cycle after its edge.
- Standard read latency: `data_out` is valid 1 cycle after the read request edge.
- FWFT read latency: 0 cycles. A word written to an empty FIFO is visible on `data_out` the cycle after the write edge.
- Pointer wrap: the low bits roll over from DEPTH-1 to 0, and the MSB toggles. No bubble is inserted.
- Reset mid-operation: all state returns to reset values immediately; any in-flight request is discarded.

## Structure
- Shared package `fifo_pkg` holds:
  - the pointer-width function `ptr_w(depth) = $clog2(depth)+1`;
  - mode constants `FIFO_MODE_STD = 0` and `FIFO_MODE_FWFT = 1`.
- One sub-module, `fifo_ptr_ctrl`: the pointer registers, accept logic, count, threshold flags and sticky error flags. It is parametrised by DEPTH, AF_LEVEL and AE_LEVEL.
- The top level holds the storage array and the read-mode output mux/register.

## Test plan
All scenarios use DATA_WIDTH=32, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2.
- Fill/drain, FWFT=0: write 0x1..0x8.
  - `full` asserts after the 8th write and `count` = 8.
  - Read 8 times: `data_out` gives 0x1..0x8, each 1 cycle after its read.
  - `empty` asserts after the last read.
- FWFT: write 0xA5A5A5A5 into an empty FIFO. `data_out` = 0xA5A5A5A5 the next cycle with no `rd_en`. Popping it gives `empty` = 1 and `data_out` = 0.
- Thresholds: write 6 words. `almost_empty` deasserts at count 3 and `almost_full` asserts at count 6. Simultaneous read and write at count 6 keeps count at 6.
- Errors: at full, pulse `wr_en`. `overflow` = 1, `count` stays 8 and the head data is unchanged. Flush: `count` = 0 and `overflow` = 0. Read while empty: `underflow` = 1.
- Boundary: at full, assert read and write together; count goes to 7. At empty, assert both; count goes to 1. 20 write/read pairs across the wrap preserve data order. With `cs` = 0, any `wr_en`/`rd_en` leaves all state unchanged.
- Reset mid-stream: assert `rst_n` = 0 at count 5 → all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_sync_fwft_pkg.sv
// fifo_pkg: shared pointer-width helper and read-mode constants for the FIFO
package fifo_pkg;
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_sync_fwft_ptr_ctrl.sv
// fifo_ptr_ctrl: pointers, accept logic, occupancy, thresholds and sticky error flags
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int PW = ptr_w(DEPTH),
  localparam int AW = PW - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic          flush,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic          o_wr_ok,
  output logic          o_rd_ok,
  output logic [AW-1:0] o_waddr,
  output logic [AW-1:0] o_raddr,
  output logic [PW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);
  logic [PW-1:0] r_wptr, r_rptr;
  logic          r_ovf, r_udf;
  logic [PW-1:0] w_count;
  assign w_count      = r_wptr - r_rptr;
  assign count        = w_count;
  assign empty        = w_count == '0;
  assign full         = w_count == PW'(DEPTH);
  assign almost_full  = int'(w_count) >= AF_LEVEL;
  assign almost_empty = int'(w_count) <= AE_LEVEL;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;
  // flush wins over both accesses, so it also vetoes the memory write
  assign o_wr_ok = cs && wr_en && !full && !flush;
  assign o_rd_ok = cs && rd_en && !empty && !flush;
  assign o_waddr = r_wptr[AW-1:0];
  assign o_raddr = r_rptr[AW-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else begin
      if (o_wr_ok) r_wptr <= r_wptr + PW'(1);
      if (o_rd_ok) r_rptr <= r_rptr + PW'(1);
      if (cs && wr_en && full) r_ovf <= 1'b1;
      if (cs && rd_en && empty) r_udf <= 1'b1;
    end
  end
endmodule

// File: rtl/fifo_sync_fwft.sv
// fifo_sync_fwft: single-clock FIFO with standard or first-word-fall-through read
module fifo_sync_fwft
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int FWFT       = FIFO_MODE_STD,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  localparam int PW = ptr_w(DEPTH),
  localparam int AW = PW - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  w_wr_ok, w_rd_ok;
  logic [AW-1:0]         w_waddr, w_raddr;
  fifo_ptr_ctrl #(.DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)) u_ctrl (
    .clk(clk), .rst_n(rst_n), .cs(cs), .flush(flush), .wr_en(wr_en), .rd_en(rd_en),
    .o_wr_ok(w_wr_ok), .o_rd_ok(w_rd_ok), .o_waddr(w_waddr), .o_raddr(w_raddr),
    .count(count), .empty(empty), .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[w_waddr] <= data_in;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dout <= '0;
    else if (flush) r_dout <= '0;
    else if (w_rd_ok) r_dout <= r_mem[w_raddr];
  end
  assign data_out = (FWFT == FIFO_MODE_FWFT) ? (empty ? '0 : r_mem[w_raddr]) : r_dout;
endmodule
